life_engine: RTL and testbench

//  Parametrised Game-of-Life compute engine for the VGA life demos. It holds the current
//  and next board and runs randomise, step and copy sequences under a start/busy/done handshake.
//  It adds configurable birth/survive rules (any B/S rule), wrap or dead-edge boundaries, a host

---
 rtl/life_engine_if.sv | 35 +++
 rtl/life_engine.sv | 163 ++++++++++++++++
 tb/tb_life_engine.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/life_engine_if.sv
// Host/display bus of the Game-of-Life engine: command handshake, rule
// configuration, host cell writes, display cell reads and status counters.
interface life_engine_if #(
  parameter int LOG_W = 6,
  parameter int LOG_H = 5,
  parameter int GEN_W = 16
);
  logic                     cmd_init;
  logic                     cmd_step;
  logic [8:0]               birth_mask;
  logic [8:0]               survive_mask;
  logic                     wrap_en;
  logic                     wr_en;
  logic [LOG_W+LOG_H-1:0]   wr_index;
  logic                     wr_data;
  logic [LOG_W+LOG_H-1:0]   rd_index;
  logic                     rd_cell;
  logic                     busy;
  logic                     done;
  logic [GEN_W-1:0]         generation;
  logic [LOG_W+LOG_H:0]     population;
  logic                     stable;

  modport master (
    output cmd_init, cmd_step, birth_mask, survive_mask, wrap_en,
           wr_en, wr_index, wr_data, rd_index,
    input  rd_cell, busy, done, generation, population, stable
  );

  modport slave (
    input  cmd_init, cmd_step, birth_mask, survive_mask, wrap_en,
           wr_en, wr_index, wr_data, rd_index,
    output rd_cell, busy, done, generation, population, stable
  );
endinterface

// File: rtl/life_engine.sv
// Game-of-Life engine: holds current and next boards, randomises the board
// from a free-running LFSR, computes one generation under any B/S rule with
// wrap or dead-edge boundaries, then copies next to current while counting
// population and detecting still lifes.
module life_engine #(
  parameter int          LOG_W = 6,
  parameter int          LOG_H = 5,
  parameter int          GEN_W = 16,
  parameter logic [15:0] SEED  = 16'h0001
) (
  input  logic          clk,
  input  logic          reset,
  life_engine_if.slave  bus
);
  localparam int IDX_W = LOG_W + LOG_H;
  localparam int N     = 1 << IDX_W;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_INIT   = 3'd1;
  localparam logic [2:0] S_UPDATE = 3'd2;
  localparam logic [2:0] S_COPY   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]       state;
  logic [IDX_W-1:0] idx;
  logic [3:0]       sub;
  logic [3:0]       cnt;
  logic [15:0]      lfsr;
  logic [N-1:0]     cur_board;
  logic [N-1:0]     nxt_board;
  logic             diff;
  logic             last_was_step;
  logic [GEN_W-1:0] gen_count;
  logic [IDX_W:0]   pop_count;
  logic             stable_flag;

  // Neighbour offsets in visiting order, two's complement.
  function automatic logic signed [1:0] nb_dx(input logic [3:0] s);
    case (s)
      4'd0, 4'd3, 4'd5: return -2'sd1;
      4'd2, 4'd4, 4'd7: return 2'sd1;
      default:          return 2'sd0;
    endcase
  endfunction

  function automatic logic signed [1:0] nb_dy(input logic [3:0] s);
    case (s)
      4'd0, 4'd1, 4'd2: return 2'sd1;
      4'd5, 4'd6, 4'd7: return -2'sd1;
      default:          return 2'sd0;
    endcase
  endfunction

  function automatic logic apply_rule(input logic alive, input logic [3:0] n,
                                      input logic [8:0] bm, input logic [8:0] sm);
    return alive ? sm[n] : bm[n];
  endfunction

  logic signed [1:0] dx;
  logic signed [1:0] dy;
  logic [LOG_W:0]    nx_ext;
  logic [LOG_H:0]    ny_ext;
  logic              nb_bit;

  // Neighbour coordinate for the current sub-cycle; the extra top bit flags
  // stepping off either edge of the board.
  always_comb begin
    dx     = nb_dx(sub);
    dy     = nb_dy(sub);
    nx_ext = {1'b0, idx[LOG_W-1:0]} + {{(LOG_W-1){dx[1]}}, dx};
    ny_ext = {1'b0, idx[IDX_W-1:LOG_W]} + {{(LOG_H-1){dy[1]}}, dy};
    nb_bit = cur_board[{ny_ext[LOG_H-1:0], nx_ext[LOG_W-1:0]}] &
             (bus.wrap_en | ~(nx_ext[LOG_W] | ny_ext[LOG_H]));
  end

  // Board storage and neighbour accumulator; not reset, INIT rewrites the board.
  always_ff @(posedge clk) begin
    case (state)
      S_IDLE: if (bus.wr_en) cur_board[bus.wr_index] <= bus.wr_data;
      S_INIT: cur_board[idx] <= lfsr[0];
      S_UPDATE: begin
        if (sub == 4'd0)      cnt <= {3'b000, nb_bit};
        else if (sub != 4'd8) cnt <= cnt + {3'b000, nb_bit};
        else nxt_board[idx] <= apply_rule(cur_board[idx], cnt,
                                          bus.birth_mask, bus.survive_mask);
      end
      S_COPY: cur_board[idx] <= nxt_board[idx];
      default: ;
    endcase
  end

  // Sequencer, LFSR and status counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_INIT;
      idx           <= '0;
      sub           <= '0;
      lfsr          <= SEED;
      diff          <= 1'b0;
      last_was_step <= 1'b0;
      gen_count     <= '0;
      pop_count     <= '0;
      stable_flag   <= 1'b0;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      case (state)
        S_IDLE: begin
          idx <= '0;
          sub <= '0;
          if (bus.cmd_init) begin
            state         <= S_INIT;
            pop_count     <= '0;
            gen_count     <= '0;
            stable_flag   <= 1'b0;
            last_was_step <= 1'b0;
          end else if (bus.cmd_step) begin
            state         <= S_UPDATE;
            diff          <= 1'b0;
            last_was_step <= 1'b1;
          end
        end
        S_INIT: begin
          pop_count <= pop_count + {{IDX_W{1'b0}}, lfsr[0]};
          idx       <= idx + 1'b1;
          if (&idx) state <= S_DONE;
        end
        S_UPDATE: begin
          if (sub == 4'd8) begin
            sub <= '0;
            idx <= idx + 1'b1;
            if (&idx) begin
              state     <= S_COPY;
              pop_count <= '0;
            end
          end else begin
            sub <= sub + 1'b1;
          end
        end
        S_COPY: begin
          pop_count <= pop_count + {{IDX_W{1'b0}}, nxt_board[idx]};
          diff      <= diff | (cur_board[idx] ^ nxt_board[idx]);
          idx       <= idx + 1'b1;
          if (&idx) state <= S_DONE;
        end
        S_DONE: begin
          if (last_was_step) begin
            gen_count   <= gen_count + 1'b1;
            stable_flag <= ~diff;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.rd_cell    = cur_board[bus.rd_index];
  assign bus.busy       = (state != S_IDLE) && (state != S_DONE);
  assign bus.done       = (state == S_DONE);
  assign bus.generation = gen_count;
  assign bus.population = pop_count;
  assign bus.stable     = stable_flag;
endmodule

// File: tb/tb_life_engine.sv
// Bench for life_engine on an 8x8 board: directed scenarios plus randomised
// boards and rules, checked against a cell-by-cell Game-of-Life model.
module tb_life_engine;
  localparam int          LW   = 3;
  localparam int          LH   = 3;
  localparam int          GW   = 16;
  localparam int          W    = 8;
  localparam int          H    = 8;
  localparam int          N    = 64;
  localparam logic [15:0] SEED = 16'h0001;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int gen_m = 0;
  logic [15:0]  m_lfsr;
  logic [N-1:0] m_board;

  life_engine_if #(.LOG_W(LW), .LOG_H(LH), .GEN_W(GW)) bus ();

  life_engine #(.LOG_W(LW), .LOG_H(LH), .GEN_W(GW), .SEED(SEED)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Free-running reference LFSR, advancing once per clock like the engine's.
  always @(posedge clk or posedge reset) begin
    if (reset) m_lfsr <= SEED;
    else       m_lfsr <= lfsr_next(m_lfsr);
  end

  function automatic logic [N-1:0] init_model(input logic [15:0] s);
    logic [N-1:0] b;
    logic [15:0] l;
    l = s;
    for (int i = 0; i < N; i++) begin
      b[i] = l[0];
      l = lfsr_next(l);
    end
    return b;
  endfunction

  function automatic logic [N-1:0] step_model(input logic [N-1:0] b, input logic [8:0] bm,
                                              input logic [8:0] sm, input logic wrap);
    logic [N-1:0] r;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        int n;
        n = 0;
        for (int dy = -1; dy <= 1; dy++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            int xx, yy;
            if (dx == 0 && dy == 0) continue;
            xx = x + dx;
            yy = y + dy;
            if (wrap) begin
              xx = (xx + W) % W;
              yy = (yy + H) % H;
            end else if (xx < 0 || xx >= W || yy < 0 || yy >= H) begin
              continue;
            end
            n += int'(b[yy * W + xx]);
          end
        end
        r[y * W + x] = b[y * W + x] ? sm[n] : bm[n];
      end
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag, input int budget, output int lat);
    bit seen;
    seen = 1'b0;
    lat = 0;
    while (!seen && lat < budget) begin
      tick();
      lat++;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    tick();
    check({tag, "_done_pulse"}, {62'd0, bus.done, bus.busy}, 64'd0);
  endtask

  task automatic write_board(input logic [N-1:0] b);
    for (int i = 0; i < N; i++) begin
      bus.wr_en    = 1'b1;
      bus.wr_index = 6'(i);
      bus.wr_data  = b[i];
      tick();
    end
    bus.wr_en = 1'b0;
  endtask

  task automatic read_board(output logic [N-1:0] b);
    for (int i = 0; i < N; i++) begin
      bus.rd_index = 6'(i);
      #1;
      b[i] = bus.rd_cell;
    end
    tick();
  endtask

  task automatic pulse_step();
    bus.cmd_step = 1'b1;
    tick();
    bus.cmd_step = 1'b0;
  endtask

  task automatic do_step(input string tag, input bit load, input logic [N-1:0] start,
                         input logic [8:0] bm, input logic [8:0] sm, input logic wrap,
                         output logic [N-1:0] got, output int lat);
    logic [N-1:0] exp_b;
    bus.birth_mask   = bm;
    bus.survive_mask = sm;
    bus.wrap_en      = wrap;
    if (load) begin
      write_board(start);
      m_board = start;
    end
    exp_b = step_model(m_board, bm, sm, wrap);
    pulse_step();
    wait_done(tag, 20 * N, lat);
    read_board(got);
    gen_m++;
    check({tag, "_board"}, got, exp_b);
    check({tag, "_population"}, 64'(bus.population), 64'($countones(exp_b)));
    check({tag, "_stable"}, 64'(bus.stable), 64'(exp_b == m_board));
    check({tag, "_generation"}, 64'(bus.generation), 64'(gen_m));
    m_board = exp_b;
  endtask

  task automatic do_init(input string tag, input bit with_step);
    logic [15:0] snap;
    logic [N-1:0] got;
    int lat;
    bus.cmd_init = 1'b1;
    bus.cmd_step = with_step;
    tick();
    snap = m_lfsr;
    bus.cmd_init = 1'b0;
    bus.cmd_step = 1'b0;
    wait_done(tag, 20 * N, lat);
    check({tag, "_latency"}, 64'(lat), 64'(N));
    m_board = init_model(snap);
    gen_m = 0;
    read_board(got);
    check({tag, "_board"}, got, m_board);
    check({tag, "_population"}, 64'(bus.population), 64'($countones(m_board)));
    check({tag, "_generation"}, 64'(bus.generation), 64'd0);
    check({tag, "_stable"}, 64'(bus.stable), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    logic [N-1:0] got, blink_v, blink_h, corners, block;
    int lat, dones;

    bus.cmd_init = 1'b0;      bus.cmd_step = 1'b0;
    bus.birth_mask = 9'h008;  bus.survive_mask = 9'h00C;
    bus.wrap_en = 1'b1;       bus.wr_en = 1'b0;
    bus.wr_index = '0;        bus.wr_data = 1'b0;
    bus.rd_index = '0;

    // Reset state, then the power-on randomise pass.
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(bus.busy), 64'd1);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_generation", 64'(bus.generation), 64'd0);
    check("rst_population", 64'(bus.population), 64'd0);
    check("rst_stable", 64'(bus.stable), 64'd0);
    reset = 1'b0;
    wait_done("init1", 20 * N, lat);
    check("init1_latency", 64'(lat), 64'(N));
    m_board = init_model(SEED);
    read_board(got);
    check("init1_board", got, m_board);
    check("init1_population", 64'(bus.population), 64'($countones(m_board)));
    check("init1_generation", 64'(bus.generation), 64'd0);

    // Blinker oscillates between vertical and horizontal.
    blink_v = '0; blink_v[19] = 1'b1; blink_v[27] = 1'b1; blink_v[35] = 1'b1;
    blink_h = '0; blink_h[26] = 1'b1; blink_h[27] = 1'b1; blink_h[28] = 1'b1;
    gen_m = 0;
    do_step("blink1", 1'b1, blink_v, 9'h008, 9'h00C, 1'b1, got, lat);
    check("step_latency", 64'(lat), 64'(10 * N));
    check("blink1_horizontal", got, blink_h);
    do_step("blink2", 1'b0, '0, 9'h008, 9'h00C, 1'b1, got, lat);
    check("blink2_vertical", got, blink_v);

    // Corner birth depends on the boundary mode.
    corners = '0; corners[63] = 1'b1; corners[56] = 1'b1; corners[7] = 1'b1;
    do_step("wrap1", 1'b1, corners, 9'h008, 9'h00C, 1'b1, got, lat);
    check("wrap1_origin_born", 64'(got[0]), 64'd1);
    do_step("wrap0", 1'b1, corners, 9'h008, 9'h00C, 1'b0, got, lat);
    check("wrap0_origin_dead", 64'(got[0]), 64'd0);

    // Block still life, then a fresh randomise clears the status.
    block = '0; block[18] = 1'b1; block[19] = 1'b1; block[26] = 1'b1; block[27] = 1'b1;
    do_step("block", 1'b1, block, 9'h008, 9'h00C, 1'b1, got, lat);
    check("block_stable_set", 64'(bus.stable), 64'd1);
    check("block_population4", 64'(bus.population), 64'd4);
    do_init("reinit", 1'b0);

    // Simultaneous commands: randomise wins.
    do_init("both_cmds", 1'b1);

    // A second cmd_step during a step is dropped.
    bus.birth_mask = 9'h008; bus.survive_mask = 9'h00C; bus.wrap_en = 1'b1;
    pulse_step();
    dones = 0;
    for (int c = 0; c < 800; c++) begin
      bus.cmd_step = (c == 100);
      tick();
      if (bus.done === 1'b1) dones++;
    end
    bus.cmd_step = 1'b0;
    check("busy_cmd_one_done", 64'(dones), 64'd1);
    check("busy_cmd_generation", 64'(bus.generation), 64'd1);
    m_board = step_model(m_board, 9'h008, 9'h00C, 1'b1);
    gen_m = 1;
    read_board(got);
    check("busy_cmd_board", got, m_board);

    // Random boards under random B/S rules and boundary modes.
    for (int r = 0; r < 4; r++) begin
      logic [N-1:0] rb;
      rb = {$urandom, $urandom};
      do_step($sformatf("rand%0d", r), 1'b1, rb, 9'($urandom_range(0, 511)),
              9'($urandom_range(0, 511)), 1'($urandom_range(0, 1)), got, lat);
    end

    // Reset mid-update aborts at once and replays the power-on randomise.
    pulse_step();
    repeat (200) tick();
    #2 reset = 1'b1;
    #1;
    check("midrst_busy", 64'(bus.busy), 64'd1);
    check("midrst_generation", 64'(bus.generation), 64'd0);
    check("midrst_done", 64'(bus.done), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    wait_done("midrst_init", 20 * N, lat);
    check("midrst_latency", 64'(lat), 64'(N));
    m_board = init_model(SEED);
    read_board(got);
    check("midrst_board", got, m_board);
    check("midrst_population", 64'(bus.population), 64'($countones(m_board)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
